imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the RV64 core: the memory end of the fetch interface, where the core drives a 64-bit PC and receives a 32-bit instruction. It accepts fetch requests via a valid/ready handshake and reads a 64-bit-wide backing array. It returns the selected 32-bit instruction, or an error code, after a configurable latency. It replaces the external C-array fetch in simulation and is the fetch target for the integrated top.

## Interface
- `ADDR_BASE`, 64'h8000_0000: byte address of array word 0.
- `DEPTH_WORDS`, 1024: number of 64-bit array words; power of two, ≥ 2.
- `LATENCY`, 1: cycles from request accept to `resp_valid`; legal range 1..15.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: fetch request present.
- `req_ready` out 1: request accepted this cycle when `req_valid` is also high.
- `req_addr` in 64: byte address (PC) of the fetch.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_inst` out 32: fetched instruction.
- `resp_err` out 2: response status; 0 = OK, 1 = misaligned, 2 = out of range.
- `ld_en` in 1: loader write strobe.
- `ld_idx` in log2(DEPTH_WORDS): array word index for the loader write.
- `ld_data` in 64: loader write data.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - BUSY: latency countdown.
  - RESP: `resp_valid` = 1, held until `resp_ready`.
- Accept means `req_valid && req_ready`. On accept:
  - Compute `off = req_addr - ADDR_BASE` (64-bit) and `idx = off[63:3]`.
  - Misaligned if `req_addr[1:0] != 0`; this check has priority over range.
  - Out of range if `req_addr < ADDR_BASE` or `idx >= DEPTH_WORDS`.
  - On OK, read array word `idx` in the accept cycle into a holding register. `req_addr[2]` = 0 selects bits [31:0]; 1 selects bits [63:32] (little-endian).
  - On error, the holding register gets 32'h0010_0073 (ebreak) and `resp_err` gets the code. The array is not read.
- Transitions:
  - IDLE, on accept: go to RESP if `LATENCY` = 1; otherwise go to BUSY with count = `LATENCY` − 1.
  - BUSY: decrement the count each cycle; go to RESP on the cycle the count reaches 0. `req_ready` = 0.
  - RESP, when `resp_ready` = 1: if `req_valid` = 1, accept the new request and go to RESP or BUSY as from IDLE; otherwise go to IDLE.
- `req_ready = (state==IDLE) || (state==RESP && resp_ready)`. This is a combinational path from `resp_ready`.
- `resp_inst` and `resp_err` stay stable while `resp_valid` is high and not taken.
- Loader:
  - `ld_en` writes `ld_data` to word `ld_idx` every cycle, in any state.
  - An accept-cycle read of the same word returns the old data.
  - Loads after accept do not alter a pending response.
- Array contents are not reset.

## Timing
- Reset values: state = IDLE; `resp_valid` = 0; `resp_inst` = 0; `resp_err` = 0; counter = 0; `req_ready` = 1 in the cycle after reset deasserts.
- `rst` mid-operation discards any pending or presented response; the next cycle is IDLE.
- A loader write during reset is still performed.
- Latency: accept in cycle t gives `resp_valid` in cycle t+`LATENCY`.
- Throughput:
  - `LATENCY` = 1 with `resp_ready` held high: one response per cycle.
  - Otherwise: one response per `LATENCY` cycles.
- Backpressure: RESP holds indefinitely; no request is accepted until the response is taken.
- Address wrap: `req_addr − ADDR_BASE` underflow is detected by the explicit `< ADDR_BASE` compare, never by the index alone.

## Structure
- Package `imem_pkg`:
  - State enum (IDLE/BUSY/RESP).
  - Error codes `ERR_OK`/`ERR_MISALIGN`/`ERR_RANGE`.
  - Constant `INST_EBREAK` = 32'h0010_0073.
- Sub-module `imem_array`: DEPTH_WORDS×64 storage with one synchronous read port (enable, index, registered data) and one write port (loader), read-old-data on collision.
- Top level holds the FSM, latency counter, address check, half-word select and response registers.

## Test plan
- Load word 0 = 64'h0000_0093_0000_0013, LATENCY = 1. Request 0x8000_0000 then 0x8000_0004, `resp_ready` = 1. Expected: 32'h0000_0013 then 32'h0000_0093 on consecutive cycles, `resp_err` = 0.
- LATENCY = 3, request 0x8000_0008. Expected: `resp_valid` exactly 3 cycles after accept; `req_ready` = 0 during BUSY.
- Request 0x8000_0002 → `resp_err` = 1, `resp_inst` = 32'h0010_0073. Request 0x7FFF_FFFC → `resp_err` = 2. Request 0x8000_2000 with DEPTH 1024 → `resp_err` = 2.
- Hold `resp_ready` = 0 for 5 cycles, change `req_addr` and pulse `ld_en` on the same word. Expected: response stays stable and unchanged; on release, the next request is accepted in the same cycle.
- Assert `rst` while in BUSY. Expected: next cycle `resp_valid` = 0, `resp_err` = 0, `req_ready` = 1; no stale response appears later.
- `ld_en` to word 5 in the same cycle as a request to 0x8000_0028. Expected: old data returned; a repeat request returns the new data.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared state, status and constant definitions for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/imem_array.sv
// 64-bit-wide instruction storage: one synchronous read port, one loader write port.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [63:0]      wr_data
);

    logic [63:0] mem [DEPTH_WORDS];

    // Both ports sample the array before the write lands, so a same-word read sees old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side memory responder: valid/ready request in, 32-bit instruction or error out
// after a fixed latency.
module imem_responder
    import imem_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [63:0]                    req_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_inst,
    output logic [1:0]                     resp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
    input  logic [63:0]                    ld_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic        accept;
    logic [1:0]  req_err;
    logic [1:0]  err_q;
    logic        data_ok;
    logic        sel_hi;
    logic [63:0] off;
    logic [63:0] word_off;
    logic [63:0] rd_data;

    assign off      = req_addr - ADDR_BASE;
    assign word_off = off >> 3;

    // Underflow below the base is caught by the explicit compare, not by the wrapped index.
    always_comb begin
        req_err = ERR_OK;
        if (req_addr[1:0] != 2'b00) begin
            req_err = ERR_MISALIGN;
        end else if ((req_addr < ADDR_BASE) || (word_off >= 64'(DEPTH_WORDS))) begin
            req_err = ERR_RANGE;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            BUSY: begin
                if (count <= 4'd1) begin
                    state_next = RESP;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    req_ready  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        accept = req_valid && req_ready;
        if (accept) begin
            if (LATENCY == 1) begin
                state_next = RESP;
            end else begin
                state_next = BUSY;
                count_next = 4'(LATENCY - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 4'd0;
            err_q   <= ERR_OK;
            data_ok <= 1'b0;
            sel_hi  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                err_q   <= req_err;
                data_ok <= (req_err == ERR_OK);
                sel_hi  <= req_addr[2];
            end
        end
    end

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .rd_en  (accept && (req_err == ERR_OK)),
        .rd_idx (word_off[IDX_W-1:0]),
        .rd_data(rd_data),
        .wr_en  (ld_en),
        .wr_idx (ld_idx),
        .wr_data(ld_data)
    );

    // The read register only updates on an accepted good fetch, so it doubles as the holding register.
    always_comb begin
        resp_err = err_q;
        if (data_ok) begin
            resp_inst = sel_hi ? rd_data[63:32] : rd_data[31:0];
        end else if (err_q != ERR_OK) begin
            resp_inst = INST_EBREAK;
        end else begin
            resp_inst = 32'h0;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: a LATENCY=1 responder checked through a response scoreboard,
// and a LATENCY=3 responder checked with directed cycle-by-cycle steps.
module tb_imem_responder;
    import imem_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_ld_en;
    logic [63:0] a_req_addr, a_ld_data;
    logic [31:0] a_resp_inst;
    logic [1:0]  a_resp_err;
    logic [9:0]  a_ld_idx;

    logic        b_rst, b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_ld_en;
    logic [63:0] b_req_addr, b_ld_data;
    logic [31:0] b_resp_inst;
    logic [1:0]  b_resp_err;
    logic [9:0]  b_ld_idx;

    int          pass_count  = 0;
    int          check_count = 0;
    logic [33:0] exp_q[$];
    logic [63:0] model_mem [DEPTH];

    imem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(a_req_addr), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_inst(a_resp_inst), .resp_err(a_resp_err), .ld_en(a_ld_en),
        .ld_idx(a_ld_idx), .ld_data(a_ld_data)
    );

    imem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_inst(b_resp_inst), .resp_err(b_resp_err), .ld_en(b_ld_en),
        .ld_idx(b_ld_idx), .ld_data(b_ld_data)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Reference behaviour: {instruction, status} for a fetch, from the bench's shadow memory.
    function automatic logic [33:0] expectedOf(input logic [63:0] addr);
        logic [63:0] off;
        logic [63:0] w;
        off = addr - BASE;
        if (addr[1:0] != 2'b00) return {INST_EBREAK, ERR_MISALIGN};
        if (addr < BASE || (off >> 3) >= 64'(DEPTH)) return {INST_EBREAK, ERR_RANGE};
        w = model_mem[off[12:3]];
        return {(addr[2] ? w[63:32] : w[31:0]), ERR_OK};
    endfunction

    task automatic loadWord(input int idx, input logic [63:0] data);
        a_ld_en   = 1'b1;
        a_ld_idx  = 10'(idx);
        a_ld_data = data;
        @(posedge clk); #1;
        a_ld_en = 1'b0;
        model_mem[idx] = data;
    endtask

    // Drives one request on DUT A, pushes its expected response at the accept cycle.
    task automatic applyStimulus(input logic [63:0] addr, output int waited);
        waited      = 0;
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        @(negedge clk);
        while (!a_req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!a_req_ready) checkOutput("accept_timeout", 64'(a_req_ready), 64'd1);
        else exp_q.push_back(expectedOf(addr));
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    // Scoreboard: every response handshake on DUT A pops and compares one expectation.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!a_rst && a_resp_valid && a_resp_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_resp", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("resp_inst", 64'(a_resp_inst), 64'(e[33:2]));
                checkOutput("resp_err", 64'(a_resp_err), 64'(e[1:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        logic [33:0] held;

        a_rst = 1'b1; a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b1;
        a_ld_en = 1'b1; a_ld_idx = 10'd0; a_ld_data = 64'h0000_0093_0000_0013;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b1;
        b_ld_en = 1'b0; b_ld_idx = 10'd0; b_ld_data = '0;

        // Word 0 is written while reset is asserted; the write must still land.
        repeat (3) @(posedge clk);
        #1;
        a_ld_en = 1'b0;
        model_mem[0] = 64'h0000_0093_0000_0013;
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_resp_valid", 64'(a_resp_valid), 64'd0);
        checkOutput("rst_resp_inst", 64'(a_resp_inst), 64'd0);
        checkOutput("rst_resp_err", 64'(a_resp_err), 64'd0);
        checkOutput("rst_req_ready", 64'(a_req_ready), 64'd1);
        @(posedge clk); #1;

        loadWord(1, 64'h0020_8133_0041_0113);
        loadWord(2, 64'hDEAD_BEEF_0123_4567);
        loadWord(5, 64'h5555_AAAA_0505_A0A0);
        loadWord(1023, 64'hFEED_FACE_0BAD_C0DE);

        // Back-to-back fetches from the same word, one per cycle.
        applyStimulus(64'h8000_0000, n);
        applyStimulus(64'h8000_0004, n);
        checkOutput("b2b_accept_wait", 64'(n), 64'd0);
        applyStimulus(64'h8000_000C, n);
        applyStimulus(64'h8000_1FFC, n);
        repeat (2) @(posedge clk);
        #1;

        // Error responses, including misalign taking priority over range.
        applyStimulus(64'h8000_0002, n);
        applyStimulus(64'h7FFF_FFFC, n);
        applyStimulus(64'h8000_2000, n);
        applyStimulus(64'h7FFF_FFFE, n);
        applyStimulus(64'h0000_0000_0000_0000, n);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: response must hold while the address and the word change underneath.
        a_resp_ready = 1'b0;
        held = expectedOf(64'h8000_0010);
        applyStimulus(64'h8000_0010, n);
        a_req_valid = 1'b1;
        a_ld_en = 1'b1; a_ld_idx = 10'd2; a_ld_data = 64'hCAFE_F00D_89AB_CDEF;
        for (int k = 0; k < 5; k++) begin
            a_req_addr = BASE + 64'(8 * k);
            @(negedge clk);
            checkOutput("hold_valid", 64'(a_resp_valid), 64'd1);
            checkOutput("hold_inst", 64'(a_resp_inst), 64'(held[33:2]));
            checkOutput("hold_err", 64'(a_resp_err), 64'(held[1:0]));
            checkOutput("hold_req_ready", 64'(a_req_ready), 64'd0);
            @(posedge clk); #1;
            if (k == 0) begin
                a_ld_en = 1'b0;
                model_mem[2] = 64'hCAFE_F00D_89AB_CDEF;
            end
        end
        a_req_addr   = 64'h8000_0014;
        a_resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_accept", 64'(a_req_ready), 64'd1);
        exp_q.push_back(expectedOf(64'h8000_0014));
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Loader write colliding with an accept-cycle read: old data, then new on repeat.
        a_ld_en = 1'b1; a_ld_idx = 10'd5; a_ld_data = 64'h1234_5678_9ABC_DEF0;
        applyStimulus(64'h8000_0028, n);
        checkOutput("collision_same_cycle", 64'(n), 64'd0);
        a_ld_en = 1'b0;
        model_mem[5] = 64'h1234_5678_9ABC_DEF0;
        applyStimulus(64'h8000_0028, n);
        applyStimulus(64'h8000_002C, n);
        repeat (2) @(posedge clk);
        #1;

        // LATENCY=3 responder: exact response cycle and no ready while counting down.
        b_ld_en = 1'b1; b_ld_idx = 10'd1; b_ld_data = 64'h0010_0593_0000_0513;
        @(posedge clk); #1;
        b_ld_en = 1'b0;
        b_req_valid = 1'b1;
        b_req_addr  = 64'h8000_0008;
        @(negedge clk);
        checkOutput("b_accept", 64'(b_req_ready), 64'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin
                checkOutput("b_busy_valid", 64'(b_resp_valid), 64'd0);
                checkOutput("b_busy_req_ready", 64'(b_req_ready), 64'd0);
            end else begin
                checkOutput("b_lat_valid", 64'(b_resp_valid), 64'd1);
                checkOutput("b_lat_inst", 64'(b_resp_inst), 64'h0000_0513);
                checkOutput("b_lat_err", 64'(b_resp_err), 64'd0);
            end
        end
        @(posedge clk); #1;

        // Reset while a misaligned fetch is counting down discards it.
        b_req_valid = 1'b1;
        b_req_addr  = 64'h8000_0002;
        @(negedge clk);
        checkOutput("b_err_accept", 64'(b_req_ready), 64'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        @(negedge clk);
        checkOutput("b_rst_valid", 64'(b_resp_valid), 64'd0);
        checkOutput("b_rst_err", 64'(b_resp_err), 64'd0);
        checkOutput("b_rst_inst", 64'(b_resp_inst), 64'd0);
        checkOutput("b_rst_req_ready", 64'(b_req_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("b_no_stale", 64'(b_resp_valid), 64'd0);
        end

        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
